// File: rtl/mix_pkg.sv
// mix_pkg
//   Shared types and constants for the master-buffer mixing path.
//   - SAMPLE_BITS / VOLUME_BITS : default sample and volume widths
//   - FREQ_RES_BITS            : phase-accumulator resolution used by the tone sources
//   - M_BUF_LEN                : master playback buffer depth
//   - mix_state_t              : sequencer states
//   - sat16()                  : clamp a wide signed value to 16 bits
package mix_pkg;

    localparam int SAMPLE_BITS   = 16;
    localparam int VOLUME_BITS   = 8;
    localparam int FREQ_RES_BITS = 24;
    localparam int M_BUF_LEN     = 256;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_ACC   = 2'd2,
        S_WRITE = 2'd3
    } mix_state_t;

    function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
        if (v > 32'sd32767)
            return 16'sh7FFF;
        else if (v < -32'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

endpackage

// File: rtl/mix_scheduler_if.sv
// mix_scheduler_if
//   Source handshake and master-buffer write bus of the mixing sequencer.
//   - src_req    : one-hot request, scheduler -> sources
//   - src_valid  : per-source response strobe, sources -> scheduler
//   - src_sample : packed signed samples, source i at [i*SAMPLE_BITS +: SAMPLE_BITS]
//   - buf_we / buf_addr / buf_wdata : master buffer write port
//   master modport = scheduler side, slave modport = sources + buffer side.
interface mix_scheduler_if #(
    parameter int NUM_SRC     = 4,
    parameter int SAMPLE_BITS = 16,
    parameter int ADDR_BITS   = 8
);
    logic [NUM_SRC-1:0]             src_req;
    logic [NUM_SRC-1:0]             src_valid;
    logic [NUM_SRC*SAMPLE_BITS-1:0] src_sample;
    logic                           buf_we;
    logic [ADDR_BITS-1:0]           buf_addr;
    logic [SAMPLE_BITS-1:0]         buf_wdata;

    modport master (
        output src_req, buf_we, buf_addr, buf_wdata,
        input  src_valid, src_sample
    );

    modport slave (
        input  src_req, buf_we, buf_addr, buf_wdata,
        output src_valid, src_sample
    );
endinterface

// File: rtl/mix_scale.sv
// mix_scale
//   Combinational signed-sample x unsigned-volume gain stage.
//   scaled = (sample * vol) >>> VW, so vol=0 mutes and full scale is (2^VW-1)/2^VW.
//   - sample : signed SW-bit input sample
//   - vol    : unsigned VW-bit gain
//   - scaled : signed SW+1-bit result (one guard bit, never overflows)
module mix_scale #(
    parameter int SW = 16,
    parameter int VW = 8
) (
    input  logic signed [SW-1:0] sample,
    input  logic        [VW-1:0] vol,
    output logic signed [SW:0]   scaled
);
    localparam int OW = SW + 1;

    // zero-extend the volume so the multiply stays signed without flipping its sign
    logic signed [SW+VW:0] prod;
    assign prod   = sample * $signed({1'b0, vol});
    assign scaled = OW'(prod >>> VW);
endmodule

// File: rtl/mix_scheduler.sv
// mix_scheduler
//   Per-sample mixing sequencer. On each sample_tick it polls every source in
//   turn, scales each returned sample by its latched volume, accumulates, and
//   writes the saturated sum into the master buffer WRITE_LAG behind play_index.
//   Ports:
//   - mclk, rst        : clock, synchronous active-high reset
//   - sample_tick      : one-cycle pulse starting a mixing pass
//   - play_index       : current master read index (latched at tick)
//   - src_enable       : per-source enable (disabled sources contribute 0)
//   - src_vol          : packed per-source volume (latched at tick)
//   - bus              : source handshake + buffer write port (master side)
//   - busy             : pass in progress
//   - underrun_flags   : sticky, source timed out
//   - overrun          : sticky, tick arrived while busy
//   - clear_flags      : clears the sticky flags (a same-cycle set wins)
module mix_scheduler #(
    parameter int NUM_SRC     = 4,
    parameter int SAMPLE_BITS = mix_pkg::SAMPLE_BITS,
    parameter int VOLUME_BITS = mix_pkg::VOLUME_BITS,
    parameter int BUF_LEN     = mix_pkg::M_BUF_LEN,
    parameter int ADDR_BITS   = $clog2(BUF_LEN),
    parameter int WRITE_LAG   = 1,
    parameter int TIMEOUT     = 16
) (
    input  logic                           mclk,
    input  logic                           rst,
    input  logic                           sample_tick,
    input  logic [ADDR_BITS-1:0]           play_index,
    input  logic [NUM_SRC-1:0]             src_enable,
    input  logic [NUM_SRC*VOLUME_BITS-1:0] src_vol,
    mix_scheduler_if.master                bus,
    output logic                           busy,
    output logic [NUM_SRC-1:0]             underrun_flags,
    output logic                           overrun,
    input  logic                           clear_flags
);
    import mix_pkg::*;

    localparam int IW    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam int ACC_W = SAMPLE_BITS + $clog2(NUM_SRC) + 1;

    mix_state_t                     state_q, state_d;
    logic [IW-1:0]                  idx_q, idx_d;
    logic [TW-1:0]                  timer_q, timer_d;
    logic signed [ACC_W-1:0]        acc_q, acc_d;
    logic [ADDR_BITS-1:0]           base_q, base_d;
    logic [NUM_SRC*VOLUME_BITS-1:0] vol_q, vol_d;
    logic signed [SAMPLE_BITS-1:0]  sample_q, sample_d;
    logic [NUM_SRC-1:0]             req_q, req_d;
    logic                           we_q, we_d;
    logic [ADDR_BITS-1:0]           addr_q, addr_d;
    logic [SAMPLE_BITS-1:0]         wdata_q, wdata_d;
    logic [NUM_SRC-1:0]             und_q, und_d;
    logic                           ovr_q, ovr_d;

    // per-index selection of the source currently being serviced
    logic signed [SAMPLE_BITS-1:0]  sel_sample;
    logic [VOLUME_BITS-1:0]         sel_vol;
    logic                           sel_en;
    logic                           sel_valid;
    logic                           next_en;

    always_comb begin
        sel_sample = '0;
        sel_vol    = '0;
        sel_en     = 1'b0;
        sel_valid  = 1'b0;
        next_en    = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (k == int'(idx_q)) begin
                sel_sample = bus.src_sample[k*SAMPLE_BITS +: SAMPLE_BITS];
                sel_vol    = vol_q[k*VOLUME_BITS +: VOLUME_BITS];
                sel_en     = src_enable[k];
                // a strobe only counts while our request is actually up
                sel_valid  = bus.src_valid[k] & req_q[k];
            end
            if (k == int'(idx_q) + 1)
                next_en = src_enable[k];
        end
    end

    logic signed [SAMPLE_BITS:0] scaled;
    logic signed [ACC_W-1:0]     acc_sum;

    mix_scale #(.SW(SAMPLE_BITS), .VW(VOLUME_BITS)) u_scale (
        .sample (sample_q),
        .vol    (sel_vol),
        .scaled (scaled)
    );

    assign acc_sum = acc_q + ACC_W'(scaled);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        timer_d  = timer_q;
        acc_d    = acc_q;
        base_d   = base_q;
        vol_d    = vol_q;
        sample_d = sample_q;
        req_d    = req_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        und_d    = clear_flags ? '0 : und_q;
        ovr_d    = clear_flags ? 1'b0 : ovr_q;

        // ticks during a pass are dropped, only flagged
        if (sample_tick && state_q != S_IDLE)
            ovr_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (sample_tick) begin
                    base_d   = play_index;
                    vol_d    = src_vol;
                    acc_d    = '0;
                    idx_d    = '0;
                    timer_d  = '0;
                    sample_d = '0;
                    // request is registered, so raise it on entry to REQ
                    req_d    = src_enable[0] ? NUM_SRC'(1) : '0;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                if (!sel_en) begin
                    req_d    = '0;
                    sample_d = '0;
                    state_d  = S_ACC;
                end else if (sel_valid) begin
                    req_d    = '0;
                    sample_d = sel_sample;
                    state_d  = S_ACC;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    req_d        = '0;
                    sample_d     = '0;
                    und_d[idx_q] = 1'b1;
                    state_d      = S_ACC;
                end else begin
                    timer_d = timer_q + 1'b1;
                    req_d   = NUM_SRC'(1) << idx_q;
                end
            end
            S_ACC: begin
                acc_d   = acc_sum;
                timer_d = '0;
                if (idx_q == IW'(NUM_SRC - 1)) begin
                    we_d    = 1'b1;
                    addr_d  = base_q - ADDR_BITS'(WRITE_LAG);
                    wdata_d = sat16(32'(acc_sum));
                    state_d = S_WRITE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    req_d   = next_en ? (NUM_SRC'(1) << (idx_q + 1'b1)) : '0;
                    state_d = S_REQ;
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            timer_q  <= '0;
            acc_q    <= '0;
            base_q   <= '0;
            vol_q    <= '0;
            sample_q <= '0;
            req_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            und_q    <= '0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            timer_q  <= timer_d;
            acc_q    <= acc_d;
            base_q   <= base_d;
            vol_q    <= vol_d;
            sample_q <= sample_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            und_q    <= und_d;
            ovr_q    <= ovr_d;
        end
    end

    assign bus.src_req     = req_q;
    assign bus.buf_we      = we_q;
    assign bus.buf_addr    = addr_q;
    assign bus.buf_wdata   = wdata_q;
    assign busy            = (state_q != S_IDLE);
    assign underrun_flags  = und_q;
    assign overrun         = ovr_q;
endmodule

// File: doc/mix_scheduler.md
Name: mix_scheduler

Overview:
Per-sample mixing sequencer for the master playback buffer.
- On each sample tick it polls every enabled audio source in turn over a req/valid handshake.
- Each returned sample is scaled by its per-source volume and accumulated; the saturated 16-bit sum is written into the master sample buffer a fixed lag behind the playback index.
- It replaces the ad-hoc lrclk-edge summing of the BRAM and triangle sources. Unresponsive sources and tick overruns are flagged for the PS to read.

Parameters:
NUM_SRC, 4, number of source ports (1..8)
SAMPLE_BITS, 16, signed sample width
VOLUME_BITS, 8, unsigned per-source volume width
BUF_LEN, 256, master buffer depth (power of 2)
ADDR_BITS, 8, log2(BUF_LEN)
WRITE_LAG, 1, write address offset behind play_index (1..BUF_LEN-1)
TIMEOUT, 16, max cycles waiting for src_valid per source

Ports:
mclk  in  1  sole clock, audio master clock domain
rst  in  1  synchronous, active-high reset
sample_tick  in  1  one-cycle pulse per output sample, already synchronous to mclk
play_index  in  ADDR_BITS  current master read index
src_enable  in  NUM_SRC  per-source enable
src_vol  in  NUM_SRC*VOLUME_BITS  per-source volume, source i at [i*VOLUME_BITS +: VOLUME_BITS]
src_req  out  NUM_SRC  one-hot sample request
src_valid  in  NUM_SRC  source response strobe
src_sample  in  NUM_SRC*SAMPLE_BITS  signed samples, packed like src_vol
buf_we  out  1  master buffer write strobe
buf_addr  out  ADDR_BITS  master buffer write address
buf_wdata  out  SAMPLE_BITS  mixed sample
busy  out  1  high in any state except IDLE
underrun_flags  out  NUM_SRC  sticky: source timed out
overrun  out  1  sticky: tick arrived while busy
clear_flags  in  1  clears the sticky flags

Behaviour:
- Reset: all outputs are 0; state is IDLE; accumulator, index and timer are 0. A reset mid-pass aborts the pass: no buf_we is issued and src_req is 0 from the first clock after rst is sampled.
- States: IDLE, REQ, ACC, WRITE.
- IDLE: on sample_tick, latch play_index into base and src_vol into vol_r, clear acc, set i=0, go to REQ.
- REQ:
  - If src_enable[i]=0: go to ACC with zero contribution; src_req stays low.
  - Otherwise assert src_req[i] (one-hot; register output).
  - If src_valid[i]=1 is seen while src_req[i] is high: capture src_sample[i] and go to ACC; src_req drops the next cycle.
  - If the timer reaches TIMEOUT first: set underrun_flags[i], contribute 0, go to ACC.
  - src_valid while src_req is low is ignored.
- ACC:
  - acc += (sample * vol_r[i]) >>> VOLUME_BITS. This is a signed×unsigned product of SAMPLE_BITS+VOLUME_BITS+1 bits with an arithmetic shift, so vol=0 mutes.
  - acc width is SAMPLE_BITS+clog2(NUM_SRC)+1, so it never overflows.
  - Next: if i==NUM_SRC-1 go to WRITE, else i++ and go to REQ.
- WRITE:
  - One cycle with buf_we=1 and buf_addr=(base-WRITE_LAG) mod BUF_LEN (e.g. base 0, lag 1 gives 255).
  - buf_wdata = acc saturated to [-32768, 32767].
  - buf_addr and buf_wdata hold their values after the write; buf_we returns to 0. Then go to IDLE.
- Latency with all sources answering in the first REQ cycle: tick at cycle t, buf_we at t+1+2*NUM_SRC (t+9 for NUM_SRC=4).
- Tick while busy (including the WRITE cycle): set overrun, drop the tick, and let the current pass complete unchanged.
- Sticky flags: if clear_flags and a flag set occur in the same cycle, the set wins.
- Volume and index changes mid-pass have no effect until the next tick.

Decomposition:
- Shared package mix_pkg holds: SAMPLE_BITS, VOLUME_BITS, FREQ_RES_BITS, M_BUF_LEN, the state enum mix_state_t, and function sat16 (wide signed value to 16-bit saturate).
- One sub-module, mix_scale: a registered-free combinational signed×unsigned scale-and-shift, reusable by future per-source gain stages.
- The FSM, timer and flags stay in mix_scheduler.

Test Plan:
- NUM_SRC=2, all enabled, vol=255, samples 1000 and -200, immediate valid, play_index=10, tick → single buf_we at addr 9, data (1000*255>>8)+(-200*255>>8)=996+(-200)=796, at tick+5.
- Saturation: 4 sources at 32767, vol=255 → wdata 32767; all at -32768 → -32768.
- Source 1 never asserts valid, TIMEOUT=16 → src_req[1] high for exactly 16 cycles, underrun_flags=0b0010, source 1 contributes 0, write still occurs; clear_flags returns the flags to 0.
- Wrap and disable: play_index=0, WRITE_LAG=1, src_enable=0 for all → src_req never asserted, buf_we with addr 255, data 0.
- Overrun: second tick 3 cycles after the first → overrun=1, exactly one buf_we observed, busy low afterward.
- Reset asserted while in REQ for source 2 → next cycle src_req=0, busy=0, no buf_we ever; a subsequent tick completes a normal pass.
